// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns MEM-stage load/store strobes into one valid/ready data-bus access,
// stalling the pipeline until the response (or a timeout) and returning registered load data.
// Ports: clk, rst (async active-low); core side mem_read, mem_write, adr, wdata, wmask -> rdata,
// stall; bus side bus_req_valid/ready, bus_we, bus_adr, bus_wdata, bus_wmask, bus_rsp_valid,
// bus_rsp_data; err (sticky timeout flag) with err_clr.
module dmem_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  output logic        err,
  input  logic        err_clr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             access, timeout;
  assign access        = mem_read | mem_write;
  assign timeout       = state == S_WAIT && !bus_rsp_valid && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign stall         = (state == S_IDLE && access) || state == S_REQ || state == S_WAIT;
  // Derived from state so an async reset drops the request immediately.
  assign bus_req_valid = state == S_REQ;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_adr   <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
      err       <= 1'b0;
    end else begin
      // A timeout in the same cycle as err_clr leaves err set.
      err <= timeout | (err & ~err_clr);
      case (state)
        S_IDLE: if (access) begin
          state     <= S_REQ;
          bus_we    <= mem_write;
          bus_adr   <= adr;
          bus_wdata <= wdata;
          bus_wmask <= mem_write ? wmask : 4'hF;
        end
        S_REQ: if (bus_req_ready) begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: if (bus_rsp_valid) begin
          state <= S_DONE;
          if (!bus_we) rdata <= bus_rsp_data;
        end else if (timeout) begin
          state <= S_DONE;
          rdata <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
